// File: rtl/seq_1010_pkg.sv
// Shared definitions for the 1010 frame transmitter and the 1010 detector:
// FSM state encodings and the default preamble pattern.
package seq_1010_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PRE  = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1010;

endpackage

// File: rtl/seq_1010_frame_tx_if.sv
// Payload handshake plus serial/debug outputs of the 1010 frame transmitter.
interface seq_1010_frame_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] Data;
  logic              Valid;
  logic              Ready;
  logic              OP;
  logic              Done;
  logic [1:0]        state;

  modport master (
    output Data,
    output Valid,
    input  Ready,
    input  OP,
    input  Done,
    input  state
  );

  modport slave (
    input  Data,
    input  Valid,
    output Ready,
    output OP,
    output Done,
    output state
  );

endinterface

// File: rtl/seq_1010_frame_tx.sv
// Serial frame transmitter: 4-bit preamble, DATA_W payload bits MSB first,
// then GAP idle cycles. OP is registered, so the first preamble bit follows acceptance by one cycle.
module seq_1010_frame_tx
  import seq_1010_pkg::*;
#(
  parameter logic [3:0] PREAMBLE = PREAMBLE_DEFAULT,
  parameter int         DATA_W   = 8,
  parameter int         GAP      = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  seq_1010_frame_tx_if.slave bus
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              op_q, op_d;
  logic              done_q, done_d;
  logic [1:0]        pre_idx_s;

  // op_d is the bit for the next cycle, so the preamble index runs one behind the counter
  assign pre_idx_s = cnt_q[1:0] - 2'd1;

  // Next-state, counter, shift register and next output bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    op_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Valid) begin
          state_d = ST_PRE;
          cnt_d   = 4'd3;
          shift_d = bus.Data;
          op_d    = PREAMBLE[3];
        end else begin
          cnt_d   = 4'd0;
        end
      end
      ST_PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LAST;
          op_d    = shift_q[DATA_W-1];
          shift_d = shift_q << 4'd1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          op_d    = PREAMBLE[pre_idx_s];
        end
      end
      ST_DATA: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          op_d    = shift_q[DATA_W-1];
          shift_d = shift_q << 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        op_d    = 1'b0;
      end
    endcase
  end

  // State, counter, payload and output registers with asynchronous clear
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= '0;
      op_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign bus.Ready = (state_q == ST_IDLE);
  assign bus.OP    = op_q;
  assign bus.Done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_seq_1010_frame_tx.sv
// Self-checking bench: a frame-level queue model predicts OP/Done/Ready every cycle,
// plus directed frames, reset abort, a bit-stream 1010 detector and a GAP=1/DATA_W=4 instance.
module tb_seq_1010_frame_tx;

  localparam logic [3:0] PRE  = 4'b1010;
  localparam int         GAP8 = 2;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  seq_1010_frame_tx_if #(.DATA_W(8)) b8 ();
  seq_1010_frame_tx_if #(.DATA_W(4)) b4 ();

  seq_1010_frame_tx #(.DATA_W(8), .GAP(2)) dut8 (.Clk(Clk), .Rst(Rst), .bus(b8.slave));
  seq_1010_frame_tx #(.DATA_W(4), .GAP(1)) dut4 (.Clk(Clk), .Rst(Rst), .bus(b4.slave));

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_last = 0;
  int          acc_prev = 0;
  int          det_cnt = 0;
  logic        m_ready;
  logic [1:0]  mq[$];
  logic [63:0] h8;
  logic [31:0] h4, d4;
  logic [3:0]  det_sr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock of dut8 traffic: model predicts the frame when a word is accepted,
  // then every cycle pops the expected {Done, OP} and checks the DUT.
  task automatic step8(input logic v, input logic [7:0] d);
    logic [1:0] e;
    logic       e_ready;
    logic       dut_acc;
    b8.Valid = v;
    b8.Data  = d;
    if (m_ready && v) begin
      for (int k = 3; k >= 0; k--) mq.push_back({1'b0, PRE[k]});
      for (int k = 7; k >= 0; k--) mq.push_back({1'b0, d[k]});
      for (int k = 0; k < GAP8; k++) mq.push_back({(k == 0), 1'b0});
    end
    dut_acc = b8.Ready && v;
    @(posedge Clk);
    #1;
    cyc++;
    if (dut_acc) begin
      acc_prev = acc_last;
      acc_last = cyc;
    end
    if (mq.size() > 0) begin
      e = mq.pop_front();
      e_ready = 1'b0;
    end else begin
      e = 2'b00;
      e_ready = 1'b1;
    end
    m_ready = e_ready;
    chk("op", 32'(b8.OP), 32'(e[0]));
    chk("done", 32'(b8.Done), 32'(e[1]));
    chk("ready", 32'(b8.Ready), 32'(e_ready));
    h8 = {h8[62:0], b8.OP};
    h4 = {h4[30:0], b4.OP};
    d4 = {d4[30:0], b4.Done};
    det_sr = {det_sr[2:0], b8.OP};
    if (det_sr == 4'b1010) det_cnt++;
  endtask

  initial begin
    Rst = 1'b0;
    b8.Valid = 1'b0;
    b8.Data = 8'h00;
    b4.Valid = 1'b0;
    b4.Data = 4'h0;
    h8 = 64'd0;
    h4 = 32'd0;
    d4 = 32'd0;
    det_sr = 4'd0;
    m_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_op", 32'(b8.OP), 32'd0);
    chk("rst_state", 32'(b8.state), 32'd0);
    chk("rst_done", 32'(b8.Done), 32'd0);
    chk("rst_ready", 32'(b8.Ready), 32'd1);
    chk("rst_op4", 32'(b4.OP), 32'd0);
    Rst = 1'b1;

    // Defaults, payload C3, accepted on the very first edge after reset
    step8(1'b1, 8'hC3);
    chk("c3_state_pre", 32'(b8.state), 32'd1);
    for (int i = 2; i <= 15; i++) begin
      step8(1'b0, 8'($urandom));
      if (i == 5) chk("c3_state_data", 32'(b8.state), 32'd2);
      if (i == 13) begin
        chk("c3_state_gap", 32'(b8.state), 32'd3);
        chk("c3_done13", 32'(b8.Done), 32'd1);
      end
      if (i == 15) begin
        chk("c3_ready15", 32'(b8.Ready), 32'd1);
        chk("c3_state_idle", 32'(b8.state), 32'd0);
      end
    end
    chk("c3_stream", 32'(h8[14:1]), 32'(14'b10101100001100));

    // GAP=1, DATA_W=4 instance, payload 9 then Data changed in flight
    b4.Valid = 1'b1;
    b4.Data = 4'h9;
    step8(1'b0, 8'h00);
    b4.Valid = 1'b0;
    b4.Data = 4'h6;
    repeat (8) step8(1'b0, 8'h00);
    chk("g1_stream", 32'(h4[8:0]), 32'(9'b101010010));
    chk("g1_done9", 32'(d4[8:0]), 32'(9'b000000001));
    step8(1'b0, 8'h00);
    chk("g1_ready", 32'(b4.Ready), 32'd1);

    // Valid held high: A5 then 5A, second accepted 15 cycles later
    repeat (2) step8(1'b0, 8'h00);
    for (int i = 1; i <= 30; i++) step8(1'b1, (i == 1) ? 8'hA5 : 8'h5A);
    chk("b2b_spacing", 32'(acc_last - acc_prev), 32'd15);
    chk("b2b_stream", 32'(h8[29:0]), 32'({15'b101010100101000, 15'b101001011010000}));

    // Data changed to FF right after accepting 00
    step8(1'b1, 8'h00);
    repeat (13) step8(1'b0, 8'hFF);
    chk("hold_stream", 32'(h8[13:0]), 32'(14'b10100000000000));
    repeat (2) step8(1'b0, 8'hFF);

    // Reset during the 3rd payload bit aborts the frame
    step8(1'b1, 8'($urandom));
    repeat (6) step8(1'b0, 8'($urandom));
    Rst = 1'b0;
    #1;
    chk("abort_op", 32'(b8.OP), 32'd0);
    chk("abort_state", 32'(b8.state), 32'd0);
    chk("abort_ready", 32'(b8.Ready), 32'd1);
    chk("abort_done", 32'(b8.Done), 32'd0);
    mq.delete();
    m_ready = 1'b1;
    #2;
    Rst = 1'b1;
    repeat (2) step8(1'b0, 8'h00);
    step8(1'b1, 8'h3C);
    repeat (14) step8(1'b0, 8'($urandom));
    chk("post_abort_stream", 32'(h8[14:1]), 32'(14'b10100011110000));

    // 1010 detector on OP: one hit per frame of payload 00
    det_cnt = 0;
    det_sr = 4'd0;
    repeat (45) step8(1'b1, 8'h00);
    repeat (2) step8(1'b0, 8'h00);
    chk("detector_hits", 32'(det_cnt), 32'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) step8(($urandom_range(0, 3) == 0), 8'($urandom));
    repeat (16) step8(1'b0, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
